// File: rtl/div_pkg.sv
// Shared definitions for the 12-by-6 restoring divider: word width,
// controller state encoding and the word driven on the bus for errors.
package div_pkg;

    localparam int unsigned DIV_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        LD_HI,
        LD_LO,
        LD_DV,
        CHECK,
        DIV,
        OUT_Q,
        OUT_R
    } div_state_e;

    localparam logic [DIV_W-1:0] DIV_ERR_WORD = 6'h3F;

endpackage

// File: rtl/div_datapath.sv
// Datapath of the restoring divider: partial remainder A, quotient/dividend
// shift register Q, divisor D, the trial subtractor and the output mux.
// Sequenced entirely by strobes from the controller in the top.
module div_datapath
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ldHi,
    input  logic         ldLo,
    input  logic         ldD,
    input  logic         shSub,
    input  logic         selQ,
    input  logic         selR,
    input  logic         errSel,
    input  logic [W-1:0] inBus,
    output logic         chkErr,
    output logic [W-1:0] outBus
);

    logic [W:0]   a_q, a_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] d_q, d_d;
    logic [W:0]   a_sh;
    logic [W+1:0] t;

    // Operand loads and one shift/trial-subtract step per shSub cycle.
    always_comb begin
        a_d  = a_q;
        q_d  = q_q;
        d_d  = d_q;
        // A < D before the shift, so the shifted value still fits in W+1 bits.
        a_sh = {a_q[W-1:0], q_q[W-1]};
        t    = {1'b0, a_sh} - {2'b00, d_q};
        if (ldHi) begin
            a_d = {1'b0, inBus};
        end
        if (ldLo) begin
            q_d = inBus;
        end
        if (ldD) begin
            d_d = inBus;
        end
        if (shSub) begin
            if (!t[W+1]) begin
                a_d = t[W:0];
                q_d = {q_q[W-2:0], 1'b1};
            end else begin
                a_d = a_sh;
                q_d = {q_q[W-2:0], 1'b0};
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else begin
            a_q <= a_d;
            q_q <= q_d;
            d_q <= d_d;
        end
    end

    // Divide-by-zero or quotient wider than W bits (high word >= divisor).
    always_comb begin
        chkErr = (d_q == '0) || (a_q[W-1:0] >= d_q);
    end

    // Result mux: quotient, remainder or the error word; zero when idle.
    always_comb begin
        outBus = '0;
        if (selQ || selR) begin
            if (errSel) begin
                outBus = W'(DIV_ERR_WORD);
            end else if (selQ) begin
                outBus = q_q;
            end else begin
                outBus = a_q[W-1:0];
            end
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential 12-by-6 unsigned restoring divider on a narrow shared bus.
// Operands arrive as dividend high, dividend low, divisor; results leave as
// quotient (with done) then remainder. Controller, iteration counter and
// error flag live here; arithmetic lives in div_datapath.
module restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] inBus,
    output logic         done,
    output logic         err,
    output logic [W-1:0] outBus
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic ldHi, ldLo, ldD, shSub, selQ, selR;
    logic chkErr;

    div_datapath #(
        .W (W)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .ldHi   (ldHi),
        .ldLo   (ldLo),
        .ldD    (ldD),
        .shSub  (shSub),
        .selQ   (selQ),
        .selR   (selR),
        .errSel (err_q),
        .inBus  (inBus),
        .chkErr (chkErr),
        .outBus (outBus)
    );

    // Controller state, iteration counter and latched error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and state-decoded strobes/outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ldHi    = 1'b0;
        ldLo    = 1'b0;
        ldD     = 1'b0;
        shSub   = 1'b0;
        selQ    = 1'b0;
        selR    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LD_HI;
                end
            end
            LD_HI: begin
                ldHi    = 1'b1;
                state_d = LD_LO;
            end
            LD_LO: begin
                ldLo    = 1'b1;
                state_d = LD_DV;
            end
            LD_DV: begin
                ldD     = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                err_d   = chkErr;
                cnt_d   = CNT_W'(W);
                state_d = chkErr ? OUT_Q : DIV;
            end
            DIV: begin
                shSub = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = OUT_Q;
                end
            end
            OUT_Q: begin
                selQ    = 1'b1;
                done    = 1'b1;
                err     = err_q;
                state_d = OUT_R;
            end
            OUT_R: begin
                selR    = 1'b1;
                err     = err_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases, reset aborts,
// held-start re-arm and randomized operands against an arithmetic model.
module tb_restoring_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] inBus;
    logic       done;
    logic       err;
    logic [5:0] outBus;

    int checks = 0;
    int errors = 0;

    restoring_divider #(
        .W (6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .inBus  (inBus),
        .done   (done),
        .err    (err),
        .outBus (outBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full operation: start, stream operands, wait for done, check both words.
    task automatic do_op(input int hi, input int lo, input int dv, input string tag);
        int  dividend;
        int  exp_q;
        int  exp_r;
        int  exp_lat;
        int  cyc;
        bit  exp_err;
        bit  seen;
        dividend = hi * 64 + lo;
        exp_err  = (dv == 0) || ((dividend / ((dv == 0) ? 1 : dv)) > 63);
        exp_q    = exp_err ? 63 : dividend / dv;
        exp_r    = exp_err ? 63 : dividend % dv;
        exp_lat  = exp_err ? 5 : 11;
        @(negedge clk);
        start = 1'b1;
        inBus = 6'($urandom);
        @(negedge clk);
        start = 1'b0;
        inBus = 6'(hi);
        @(negedge clk);
        inBus = 6'(lo);
        @(negedge clk);
        inBus = 6'(dv);
        cyc  = 3;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            inBus = 6'($urandom);
            if (done === 1'b1) seen = 1'b1;
        end
        chk({tag, " latency"}, 16'(cyc), 16'(exp_lat));
        chk({tag, " quotient"}, {10'd0, outBus}, 16'(exp_q));
        chk({tag, " err@done"}, {15'd0, err}, {15'd0, exp_err});
        @(negedge clk);
        chk({tag, " remainder"}, {10'd0, outBus}, 16'(exp_r));
        chk({tag, " err@rem"}, {15'd0, err}, {15'd0, exp_err});
        chk({tag, " done@rem"}, {15'd0, done}, 16'd0);
        @(negedge clk);
        chk({tag, " idle bus"}, {10'd0, outBus}, 16'd0);
        chk({tag, " idle done/err"}, {14'd0, done, err}, 16'd0);
    endtask

    initial begin
        int hi;
        int lo;
        int dv;
        int ndone;
        int first_done;
        int second_done;
        int cyc;
        bit prev_done;

        rst   = 1'b1;
        start = 1'b0;
        inBus = '0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {8'd0, done, err, outBus}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset idle", {8'd0, done, err, outBus}, 16'd0);

        do_op(1, 36, 7, "100/7");
        do_op(62, 63, 63, "4031/63");
        do_op(25, 17, 0, "div0");
        do_op(7, 0, 7, "overflow");
        do_op(6, 63, 7, "boundary");
        do_op(0, 0, 1, "zero dividend");

        // Reset during the third DIV cycle.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        inBus = 6'd1;
        @(negedge clk);
        inBus = 6'd36;
        @(negedge clk);
        inBus = 6'd7;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst mid-DIV", {8'd0, done, err, outBus}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(1, 36, 7, "after rst");

        // Reset while the error result is on the bus must clear it at once.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        inBus = 6'd9;
        @(negedge clk);
        inBus = 6'd9;
        @(negedge clk);
        inBus = 6'd0;
        cyc = 3;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("err-path reach done", {15'd0, done}, 16'd1);
        rst = 1'b1;
        #1;
        chk("rst in OUT_Q", {8'd0, done, err, outBus}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(1, 36, 7, "after rst2");

        // start held high for 30 cycles with a repeating 100/7 stream.
        @(negedge clk);
        start       = 1'b1;
        inBus       = 6'($urandom);
        ndone       = 0;
        first_done  = 0;
        second_done = 0;
        prev_done   = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k % 13 == 1) inBus = 6'd1;
            else if (k % 13 == 2) inBus = 6'd36;
            else if (k % 13 == 3) inBus = 6'd7;
            else inBus = 6'($urandom);
            if (prev_done) begin
                chk("held remainder", {10'd0, outBus}, 16'd2);
            end
            prev_done = (done === 1'b1);
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) first_done = k;
                if (ndone == 2) second_done = k;
                chk("held quotient", {10'd0, outBus}, 16'd14);
                chk("held err", {15'd0, err}, 16'd0);
            end
        end
        start = 1'b0;
        chk("held done count", 16'(ndone), 16'd2);
        chk("held first done", 16'(first_done), 16'd11);
        chk("held spacing", 16'(second_done - first_done), 16'd13);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Random operands, biased towards non-overflowing divisions.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                hi = int'($urandom_range(0, 63));
                dv = int'($urandom_range(0, 63));
            end else begin
                dv = int'($urandom_range(1, 63));
                hi = int'($urandom_range(0, dv - 1));
            end
            lo = int'($urandom_range(0, 63));
            do_op(hi, lo, dv, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
